// File: rtl/bitwise_logic_pkg.sv
// Shared operation encodings and the width-generic bitwise evaluator for the
// pipelined logic unit.
package bitwise_logic_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_PASS = 3'd7
    } logic_op_e;

    // Evaluated at full 64-bit width; callers truncate to their own WIDTH.
    function automatic logic [MAX_WIDTH-1:0] logic_op_eval(
        input logic_op_e            op,
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b
    );
        logic [MAX_WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_NAND: r = ~(a & b);
            OP_XNOR: r = ~(a ^ b);
            OP_ANDN: r = a & ~b;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bitwise_pipe_stage.sv
// One register stage of the logic pipe: valid bit, result word and zero flag,
// advancing only when the downstream ready chain allows it.
module bitwise_pipe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_in,
    input  logic             v_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             zero_i,
    output logic             v_o,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;

    // Payload only moves with a valid beat; an empty beat keeps the old word.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        zero_d = zero_q;
        if (adv_in) begin
            v_d = v_i;
            if (v_i) begin
                data_d = data_i;
                zero_d = zero_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= 1'b0;
            data_q <= '0;
            zero_q <= 1'b0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            zero_q <= zero_d;
        end
    end

    assign v_o    = v_q;
    assign data_o = data_q;
    assign zero_o = zero_q;

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Pipelined bitwise logic unit: result computed in front of stage 0, then
// carried through STAGES register stages with a full-throughput ready chain.
module bitwise_logic_pipe
    import bitwise_logic_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_1,
    input  logic [WIDTH-1:0] i_2,
    input  logic [2:0]       i_op,
    input  logic             enable,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o,
    output logic             o_zero
);

    logic [WIDTH-1:0]              res;
    logic                          res_zero;
    logic [STAGES-1:0]             adv;
    logic [STAGES-1:0]             v;
    logic [STAGES-1:0]             zero;
    logic [STAGES-1:0][WIDTH-1:0]  data;

    always_comb begin
        res = '0;
        if (enable) begin
            res = WIDTH'(logic_op_eval(logic_op_e'(i_op), 64'(i_1), 64'(i_2)));
        end
        res_zero = (res == '0);
    end

    // Handshake: a beat transfers on a port when valid && ready at the rising
    // edge; valid never waits on ready, and a stage may refill in the same
    // cycle it drains, so a full pipe with o_ready=1 still accepts input.
    always_comb begin
        adv[STAGES-1] = ~v[STAGES-1] | o_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = ~v[k] | adv[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_in;
        logic [WIDTH-1:0] d_in;
        logic             z_in;

        if (k == 0) begin : g_head
            assign v_in = i_valid;
            assign d_in = res;
            assign z_in = res_zero;
        end else begin : g_body
            assign v_in = v[k-1];
            assign d_in = data[k-1];
            assign z_in = zero[k-1];
        end

        bitwise_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .adv_in (adv[k]),
            .v_i    (v_in),
            .data_i (d_in),
            .zero_i (z_in),
            .v_o    (v[k]),
            .data_o (data[k]),
            .zero_o (zero[k])
        );
    end

    assign i_ready = adv[0];
    assign o_valid = v[STAGES-1];
    assign o       = data[STAGES-1];
    assign o_zero  = zero[STAGES-1];

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Scoreboard bench for bitwise_logic_pipe: a 2-stage/32-bit unit for directed
// scenarios plus 1-stage/8-bit and 4-stage/64-bit units for random traffic.
module tb_bitwise_logic_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        i_valid, i_ready, enable, o_valid, o_ready, o_zero;
    logic [2:0]  i_op;
    logic [31:0] i_1, i_2, o;

    logic        s1_i_valid, s1_i_ready, s1_enable, s1_o_valid, s1_o_ready, s1_o_zero;
    logic [2:0]  s1_i_op;
    logic [7:0]  s1_i_1, s1_i_2, s1_o;

    logic        s4_i_valid, s4_i_ready, s4_enable, s4_o_valid, s4_o_ready, s4_o_zero;
    logic [2:0]  s4_i_op;
    logic [63:0] s4_i_1, s4_i_2, s4_o;

    bitwise_logic_pipe #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
        .i_1(i_1), .i_2(i_2), .i_op(i_op), .enable(enable),
        .o_valid(o_valid), .o_ready(o_ready), .o(o), .o_zero(o_zero)
    );

    bitwise_logic_pipe #(.WIDTH(8), .STAGES(1)) dut_s1 (
        .clk(clk), .rst(rst), .i_valid(s1_i_valid), .i_ready(s1_i_ready),
        .i_1(s1_i_1), .i_2(s1_i_2), .i_op(s1_i_op), .enable(s1_enable),
        .o_valid(s1_o_valid), .o_ready(s1_o_ready), .o(s1_o), .o_zero(s1_o_zero)
    );

    bitwise_logic_pipe #(.WIDTH(64), .STAGES(4)) dut_s4 (
        .clk(clk), .rst(rst), .i_valid(s4_i_valid), .i_ready(s4_i_ready),
        .i_1(s4_i_1), .i_2(s4_i_2), .i_op(s4_i_op), .enable(s4_enable),
        .o_valid(s4_o_valid), .o_ready(s4_o_ready), .o(s4_o), .o_zero(s4_o_zero)
    );

    int checks = 0;
    int errors = 0;

    // Entries are {zero_flag, result[63:0]}.
    logic [64:0] exp_q[$];
    logic [64:0] q1[$];
    logic [64:0] q4[$];

    logic        smp_acc, smp_fire, smp_iready, smp_ovalid, smp_zero;
    logic [31:0] smp_o;

    function automatic logic [64:0] model(input int w, input logic [2:0] op,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic en);
        logic [63:0] r, mask;
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = ~(a | b);
            3'd4: r = ~(a & b);
            3'd5: r = ~(a ^ b);
            3'd6: r = a & ~b;
            default: r = a;
        endcase
        r = en ? (r & mask) : 64'd0;
        return {(r == 64'd0), r};
    endfunction

    // Drives one cycle on the main unit, samples outputs mid-cycle and pushes
    // the model result for any beat that will be accepted at the next edge.
    task automatic drive_main(input logic v, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic en, input logic rdy);
        @(negedge clk);
        i_valid = v;
        i_op    = op;
        i_1     = a;
        i_2     = b;
        enable  = en;
        o_ready = rdy;
        #1;
        smp_iready = i_ready;
        smp_ovalid = o_valid;
        smp_o      = o;
        smp_zero   = o_zero;
        smp_acc    = v && i_ready;
        smp_fire   = o_valid && rdy;
        if (smp_acc) exp_q.push_back(model(32, op, 64'(a), 64'(b), en));
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b1; i_op = 3'd1; i_1 = 32'hDEAD_BEEF; i_2 = 32'h1234_5678;
        enable = 1'b1; o_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0 || o !== 32'd0 || o_zero !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs got v=%b o=%h z=%b exp 0 00000000 0", o_valid, o, o_zero);
            end
        end
        rst = 1'b0;
        i_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (i_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b exp 1", i_ready);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_capture got o_valid=%b exp 0", o_valid);
            end
        end
    endtask

    task automatic test_op_sweep();
        logic [31:0] sweep_exp [8];
        logic [64:0] e;
        int nout;
        int first_acc;
        sweep_exp = '{32'h0000_0292, 32'h0000_1BDF, 32'h0000_194D, 32'hFFFF_E420,
                      32'hFFFF_FD6D, 32'hFFFF_E6B2, 32'h0000_100D, 32'h0000_129F};
        nout = 0;
        first_acc = -1;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) drive_main(1'b1, 3'(c), 32'h0000_129F, 32'h0000_0BD2, 1'b1, 1'b1);
            else       drive_main(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1);
            if (smp_acc && first_acc < 0) first_acc = c;
            if (smp_fire) begin
                checks++;
                if (nout >= 8 || smp_o !== sweep_exp[nout] || c != first_acc + 2 + nout) begin
                    errors++;
                    $display("FAIL sweep_result idx=%0d cycle=%0d got %h exp %h at cycle %0d",
                             nout, c, smp_o, sweep_exp[nout % 8], first_acc + 2 + nout);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sweep_scoreboard got unexpected output %h exp none", smp_o);
                end else begin
                    e = exp_q.pop_front();
                    if (smp_o !== e[31:0] || smp_zero !== e[64]) begin
                        errors++;
                        $display("FAIL sweep_scoreboard got %h/%b exp %h/%b", smp_o, smp_zero, e[31:0], e[64]);
                    end
                end
                nout++;
            end
        end
        checks++;
        if (nout != 8) begin
            errors++;
            $display("FAIL sweep_count got %0d exp 8", nout);
        end
    endtask

    task automatic test_enable();
        logic [2:0]  ops  [3];
        logic [31:0] bs   [3];
        logic        ens  [3];
        logic [31:0] eo   [3];
        logic        ez   [3];
        logic [64:0] e;
        int nout;
        ops = '{3'd1, 3'd1, 3'd0};
        bs  = '{32'hA849_2525, 32'hA849_2525, 32'h0000_0000};
        ens = '{1'b0, 1'b1, 1'b1};
        eo  = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        ez  = '{1'b1, 1'b0, 1'b1};
        nout = 0;
        for (int c = 0; c < 9; c++) begin
            if (c < 3) drive_main(1'b1, ops[c], 32'hFFFF_FFFF, bs[c], ens[c], 1'b1);
            else       drive_main(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1);
            if (smp_fire) begin
                checks++;
                if (nout >= 3 || smp_o !== eo[nout % 3] || smp_zero !== ez[nout % 3]) begin
                    errors++;
                    $display("FAIL enable_zero idx=%0d got o=%h z=%b exp o=%h z=%b",
                             nout, smp_o, smp_zero, eo[nout % 3], ez[nout % 3]);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL enable_scoreboard got unexpected output %h exp none", smp_o);
                end else begin
                    e = exp_q.pop_front();
                    if (smp_o !== e[31:0] || smp_zero !== e[64]) begin
                        errors++;
                        $display("FAIL enable_scoreboard got %h/%b exp %h/%b", smp_o, smp_zero, e[31:0], e[64]);
                    end
                end
                nout++;
            end
        end
        checks++;
        if (nout != 3) begin
            errors++;
            $display("FAIL enable_count got %0d exp 3", nout);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, first_res;
        logic [64:0] e;
        logic        rdy;
        int acc, nout;
        acc = 0;
        nout = 0;
        first_res = '0;
        for (int c = 0; c < 40; c++) begin
            a = $urandom;
            b = $urandom;
            rdy = !(c >= 2 && c <= 6);
            drive_main(acc < 6, 3'd2, a, b, 1'b1, rdy);
            if (smp_acc && acc == 0) first_res = a ^ b;
            if (smp_acc) acc++;
            if (c >= 2 && c <= 6) begin
                checks++;
                if (smp_iready !== 1'b0 || acc != 2) begin
                    errors++;
                    $display("FAIL bp_ready cycle=%0d got i_ready=%b accepts=%0d exp 0 and 2", c, smp_iready, acc);
                end
                checks++;
                if (smp_ovalid !== 1'b1 || smp_o !== first_res) begin
                    errors++;
                    $display("FAIL bp_hold cycle=%0d got v=%b o=%h exp 1 %h", c, smp_ovalid, smp_o, first_res);
                end
            end
            if (smp_fire) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_scoreboard got unexpected output %h exp none", smp_o);
                end else begin
                    e = exp_q.pop_front();
                    if (smp_o !== e[31:0] || smp_zero !== e[64]) begin
                        errors++;
                        $display("FAIL bp_scoreboard idx=%0d got %h/%b exp %h/%b", nout, smp_o, smp_zero, e[31:0], e[64]);
                    end
                end
                nout++;
            end
        end
        checks++;
        if (acc != 6 || nout != 6 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count got accepts=%0d outputs=%0d pending=%0d exp 6 6 0", acc, nout, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [64:0] e;
        int nout;
        int accs;
        accs = 0;
        for (int c = 0; c < 2; c++) begin
            drive_main(1'b1, 3'd2, 32'hCAFE_0000 + 32'(c), 32'h0000_FFFF, 1'b1, 1'b0);
            if (smp_acc) accs++;
        end
        checks++;
        if (accs != 2) begin
            errors++;
            $display("FAIL midrst_fill got accepts=%0d exp 2", accs);
        end
        @(negedge clk);
        rst = 1'b1;
        i_valid = 1'b1;
        o_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        i_valid = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (o_valid !== 1'b0 || o !== 32'd0 || o_zero !== 1'b0 || i_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_clear got v=%b o=%h z=%b rdy=%b exp 0 00000000 0 1", o_valid, o, o_zero, i_ready);
        end
        nout = 0;
        for (int c = 0; c < 8; c++) begin
            drive_main(c == 0, 3'd5, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b1);
            if (smp_fire) begin
                checks++;
                if (c != 2 || smp_o !== 32'hE2C4_A688 || smp_zero !== 1'b0) begin
                    errors++;
                    $display("FAIL midrst_post cycle=%0d got %h/%b exp cycle 2 e2c4a688/0", c, smp_o, smp_zero);
                end
                if (exp_q.size() != 0) e = exp_q.pop_front();
                nout++;
            end
        end
        checks++;
        if (nout != 1) begin
            errors++;
            $display("FAIL midrst_count got %0d outputs exp 1", nout);
        end
    endtask

    task automatic test_random_s1();
        logic [64:0] e;
        logic        prev_hold, prev_z;
        logic [7:0]  prev_o;
        prev_hold = 1'b0;
        prev_o = '0;
        prev_z = 1'b0;
        for (int c = 0; c < 1020; c++) begin
            @(negedge clk);
            s1_i_valid = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            s1_i_op    = 3'($urandom_range(0, 7));
            s1_i_1     = 8'($urandom);
            s1_i_2     = 8'($urandom);
            s1_enable  = ($urandom_range(0, 7) != 0);
            s1_o_ready = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (prev_hold) begin
                checks++;
                if (s1_o_valid !== 1'b1 || s1_o !== prev_o || s1_o_zero !== prev_z) begin
                    errors++;
                    $display("FAIL s1_stable cycle=%0d got v=%b o=%h z=%b exp 1 %h %b", c, s1_o_valid, s1_o, s1_o_zero, prev_o, prev_z);
                end
            end
            if (s1_i_valid && s1_i_ready)
                q1.push_back(model(8, s1_i_op, 64'(s1_i_1), 64'(s1_i_2), s1_enable));
            if (s1_o_valid && s1_o_ready) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL s1_scoreboard cycle=%0d got unexpected %h exp none", c, s1_o);
                end else begin
                    e = q1.pop_front();
                    if (s1_o !== e[7:0] || s1_o_zero !== e[64]) begin
                        errors++;
                        $display("FAIL s1_scoreboard cycle=%0d got %h/%b exp %h/%b", c, s1_o, s1_o_zero, e[7:0], e[64]);
                    end
                end
            end
            prev_hold = s1_o_valid && !s1_o_ready;
            prev_o    = s1_o;
            prev_z    = s1_o_zero;
        end
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL s1_drain got %0d pending exp 0", q1.size());
        end
    endtask

    task automatic test_random_s4();
        logic [64:0] e;
        logic        prev_hold, prev_z;
        logic [63:0] prev_o;
        prev_hold = 1'b0;
        prev_o = '0;
        prev_z = 1'b0;
        for (int c = 0; c < 1020; c++) begin
            @(negedge clk);
            s4_i_valid = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            s4_i_op    = 3'($urandom_range(0, 7));
            s4_i_1     = {32'($urandom), 32'($urandom)};
            s4_i_2     = {32'($urandom), 32'($urandom)};
            s4_enable  = ($urandom_range(0, 7) != 0);
            s4_o_ready = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (prev_hold) begin
                checks++;
                if (s4_o_valid !== 1'b1 || s4_o !== prev_o || s4_o_zero !== prev_z) begin
                    errors++;
                    $display("FAIL s4_stable cycle=%0d got v=%b o=%h z=%b exp 1 %h %b", c, s4_o_valid, s4_o, s4_o_zero, prev_o, prev_z);
                end
            end
            if (s4_i_valid && s4_i_ready)
                q4.push_back(model(64, s4_i_op, s4_i_1, s4_i_2, s4_enable));
            if (s4_o_valid && s4_o_ready) begin
                checks++;
                if (q4.size() == 0) begin
                    errors++;
                    $display("FAIL s4_scoreboard cycle=%0d got unexpected %h exp none", c, s4_o);
                end else begin
                    e = q4.pop_front();
                    if (s4_o !== e[63:0] || s4_o_zero !== e[64]) begin
                        errors++;
                        $display("FAIL s4_scoreboard cycle=%0d got %h/%b exp %h/%b", c, s4_o, s4_o_zero, e[63:0], e[64]);
                    end
                end
            end
            prev_hold = s4_o_valid && !s4_o_ready;
            prev_o    = s4_o;
            prev_z    = s4_o_zero;
        end
        checks++;
        if (q4.size() != 0) begin
            errors++;
            $display("FAIL s4_drain got %0d pending exp 0", q4.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        s1_i_valid = 1'b0; s1_i_op = '0; s1_i_1 = '0; s1_i_2 = '0; s1_enable = 1'b0; s1_o_ready = 1'b0;
        s4_i_valid = 1'b0; s4_i_op = '0; s4_i_1 = '0; s4_i_2 = '0; s4_enable = 1'b0; s4_o_ready = 1'b0;
        test_reset();
        test_op_sweep();
        test_enable();
        test_back_to_back();
        test_reset_mid();
        test_random_s1();
        test_random_s4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
